// File: rtl/stage_fetch.sv
// IF stage: PC register, word-addressed instruction memory with debug write port, IF/ID latch.
// Optional halt detection is compiled in with `define STAGE_FETCH_HALT_EN.
module stage_fetch #(
    parameter int NB_PC      = 32,
    parameter int NB_INSTR   = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int NB_ADDR    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic                i_pc_write,
    input  logic                i_write_IF_ID,
    input  logic                i_branch_taken,
    input  logic [NB_PC-1:0]    i_branch_addr,
    input  logic                i_jump,
    input  logic [NB_PC-1:0]    i_jump_addr,
    input  logic                i_imem_wr_en,
    input  logic [NB_ADDR-1:0]  i_imem_wr_addr,
    input  logic [NB_INSTR-1:0] i_imem_wr_data,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_INSTR-1:0] o_instruction,
    output logic [NB_PC-1:0]    o_pc_current,
    output logic                o_halt
);

    logic [NB_INSTR-1:0] imem_q [IMEM_DEPTH];
    logic [NB_PC-1:0]    pc_q;
    logic [NB_PC-1:0]    if_pc_q;
    logic [NB_INSTR-1:0] if_instr_q;

    logic [NB_INSTR-1:0] fetch_word_d;
    logic [NB_PC-1:0]    pc_plus1_d;
    logic                redirect_d;
    logic [NB_PC-1:0]    redirect_pc_d;

    assign fetch_word_d  = imem_q[pc_q[NB_ADDR-1:0]];
    assign pc_plus1_d    = pc_q + NB_PC'(1);
    assign redirect_d    = i_branch_taken | i_jump;
    assign redirect_pc_d = i_branch_taken ? i_branch_addr : i_jump_addr;

    // Program memory survives reset so a debugger can rerun the loaded program.
    always_ff @(posedge clk) begin
        if (i_imem_wr_en) begin
            imem_q[i_imem_wr_addr] <= i_imem_wr_data;
        end
    end

`ifdef STAGE_FETCH_HALT_EN
    localparam logic [NB_INSTR-1:0] HALT_WORD = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HALTED  = 2'd2
    } halt_state_e;

    halt_state_e state_q;
    logic        halt_q;

    assign o_halt = halt_q;
`else
    assign o_halt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
`ifdef STAGE_FETCH_HALT_EN
            state_q    <= ST_IDLE;
            halt_q     <= 1'b0;
`endif
        end else if (!i_enable) begin
            pc_q <= pc_q;
        end else if (redirect_d) begin
            // Redirect beats hazard holds; a pending HALT here was wrong-path.
            pc_q       <= redirect_pc_d;
            if_pc_q    <= '0;
            if_instr_q <= '0;
`ifdef STAGE_FETCH_HALT_EN
            if (state_q == ST_PENDING) begin
                state_q <= ST_IDLE;
            end
        end else if (state_q == ST_HALTED) begin
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else if (state_q == ST_PENDING) begin
            if (i_write_IF_ID) begin
                state_q    <= ST_HALTED;
                halt_q     <= 1'b1;
                if_pc_q    <= '0;
                if_instr_q <= '0;
            end
        end else begin
            if (i_write_IF_ID) begin
                if_pc_q    <= pc_plus1_d;
                if_instr_q <= fetch_word_d;
            end
            // Once HALT is latched the PC stops advancing.
            if (i_write_IF_ID && (fetch_word_d == HALT_WORD)) begin
                state_q <= ST_PENDING;
            end else if (i_pc_write) begin
                pc_q <= pc_plus1_d;
            end
        end
`else
        end else begin
            if (i_pc_write) begin
                pc_q <= pc_plus1_d;
            end
            if (i_write_IF_ID) begin
                if_pc_q    <= pc_plus1_d;
                if_instr_q <= fetch_word_d;
            end
        end
`endif
    end

    assign o_pc          = if_pc_q;
    assign o_instruction = if_instr_q;
    assign o_pc_current  = pc_q;

endmodule
